// File: rtl/life_game_step_engine_if.sv
// Cell bus between the Life step engine and the display/storage device.
// master (engine): drives cell_write / cell_address / cell_data_in, samples cell_data_out.
// slave  (device): returns cell_data_out combinationally from cell_address.
// cell_address = {row[5:0], half}; half 0 = columns 0..31, half 1 = columns 32..63.
interface life_game_step_engine_if;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 32;

  logic              cell_write;
  logic [ADDR_W-1:0] cell_address;
  logic [DATA_W-1:0] cell_data_in;
  logic [DATA_W-1:0] cell_data_out;

  modport master (
    output cell_write,
    output cell_address,
    output cell_data_in,
    input  cell_data_out
  );

  modport slave (
    input  cell_write,
    input  cell_address,
    input  cell_data_in,
    output cell_data_out
  );
endinterface

// File: rtl/life_game_step_engine.sv
// Conway's Life generation engine for a ROWS x 64 world.
// Reads the front buffer row by row over the cell bus, keeps a three-row window
// (prev/cur/next), writes each new row into the back buffer and then pulses
// world_clock so the device swaps buffers.
// Ports:
//   clock, reset_n  : clock, asynchronous active-low reset
//   start           : one-cycle request for a single generation (sampled in IDLE)
//   run             : level, free-running generations every PERIOD cycles
//   cell_bus        : cell bus master (write strobe, address, write data, read data)
//   world_clock     : one-cycle buffer-swap pulse
//   busy            : engine owns the cell bus
//   done            : one-cycle pulse, generation committed
//   generation      : committed generation count, wraps
module life_game_step_engine #(
  parameter int unsigned ROWS      = 48,
  parameter bit          WRAP      = 1'b1,
  parameter int unsigned PERIOD    = 25000000,
  parameter int unsigned GEN_WIDTH = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          run,
  life_game_step_engine_if.master       cell_bus,
  output logic                          world_clock,
  output logic                          busy,
  output logic                          done,
  output logic [GEN_WIDTH-1:0]          generation
);

  localparam int unsigned ROW_W  = 6;
  localparam int unsigned ADDR_W = ROW_W + 1;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LINE_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(PERIOD - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE_LO,
    S_WRITE_HI,
    S_FETCH_LO,
    S_FETCH_HI,
    S_SWAP
  } state_t;

  state_t              state_q;
  logic [ROW_W-1:0]    row_q;
  logic [2:0]          ld_cnt_q;
  logic [CNT_W-1:0]    per_cnt_q;
  logic [LINE_W-1:0]   prev_q, cur_q, next_q;
  logic [LINE_W-1:0]   prev_d, cur_d, next_d;
  logic                cell_write_q;
  logic [ADDR_W-1:0]   cell_address_q;
  logic [DATA_W-1:0]   cell_data_in_q;
  logic                world_clock_q, busy_q, done_q;
  logic [GEN_WIDTH-1:0] generation_q;

  logic [ROW_W:0]      row_p2;
  logic                fetch_oob;
  logic [ROW_W-1:0]    fetch_row;
  logic [ROW_W-1:0]    row_inc;
  logic                zero_word;
  logic [DATA_W-1:0]   fetch_word;
  logic                period_hit;
  logic                load_go;
  logic [LINE_W-1:0]   pw, pe, cw, ce, nw, ne;
  logic [LINE_W-1:0]   new_row;

  // Bit c of the result holds column c-1 (west neighbour); column 0 wraps to 63 or sees a dead cell.
  function automatic logic [LINE_W-1:0] sh_w(input logic [LINE_W-1:0] x);
    return {x[LINE_W-2:0], (WRAP ? x[LINE_W-1] : 1'b0)};
  endfunction

  // Bit c of the result holds column c+1 (east neighbour); column 63 wraps to 0 or sees a dead cell.
  function automatic logic [LINE_W-1:0] sh_e(input logic [LINE_W-1:0] x);
    return {(WRAP ? x[0] : 1'b0), x[LINE_W-1:1]};
  endfunction

  // Population count of the 8 neighbour bits.
  function automatic logic [3:0] count8(input logic [7:0] b);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(b[i]);
    return n;
  endfunction

  // Address of LOAD word k: rows ROWS-1, 0, 1, low half then high half each.
  function automatic logic [ADDR_W-1:0] load_addr(input logic [2:0] k);
    logic [ROW_W-1:0] r;
    case (k[2:1])
      2'd0:    r = LAST_ROW;
      2'd1:    r = '0;
      default: r = ROW_W'(1);
    endcase
    return {r, k[0]};
  endfunction

  // Row fetched in FETCH states is (r+2) mod ROWS; oob marks rows past the bottom edge.
  assign row_p2    = {1'b0, row_q} + (ROW_W+1)'(2);
  assign fetch_oob = (row_p2 >= (ROW_W+1)'(ROWS));
  assign fetch_row = fetch_oob ? ROW_W'(row_p2 - (ROW_W+1)'(ROWS)) : row_p2[ROW_W-1:0];
  assign row_inc   = row_q + ROW_W'(1);

  // Without wrap, rows -1 and ROWS read as dead; the bus cycle is spent regardless.
  always_comb begin
    zero_word = 1'b0;
    if (!WRAP) begin
      if (state_q == S_LOAD && ld_cnt_q < 3'd2) zero_word = 1'b1;
      if ((state_q == S_FETCH_LO || state_q == S_FETCH_HI) && fetch_oob) zero_word = 1'b1;
    end
  end

  assign fetch_word = zero_word ? '0 : cell_bus.cell_data_out;

  // Next value of the three-row window.
  always_comb begin
    prev_d = prev_q;
    cur_d  = cur_q;
    next_d = next_q;
    case (state_q)
      S_LOAD: begin
        case (ld_cnt_q)
          3'd0:    prev_d[DATA_W-1:0]      = fetch_word;
          3'd1:    prev_d[LINE_W-1:DATA_W] = fetch_word;
          3'd2:    cur_d[DATA_W-1:0]       = fetch_word;
          3'd3:    cur_d[LINE_W-1:DATA_W]  = fetch_word;
          3'd4:    next_d[DATA_W-1:0]      = fetch_word;
          3'd5:    next_d[LINE_W-1:DATA_W] = fetch_word;
          default: ;
        endcase
      end
      S_FETCH_LO: begin
        prev_d             = cur_q;
        cur_d              = next_q;
        next_d[DATA_W-1:0] = fetch_word;
      end
      S_FETCH_HI: next_d[LINE_W-1:DATA_W] = fetch_word;
      default: ;
    endcase
  end

  // The new row is taken from the window's next value so the word completing the
  // window this cycle is already included when cell_data_in is registered.
  assign pw = sh_w(prev_d);
  assign pe = sh_e(prev_d);
  assign cw = sh_w(cur_d);
  assign ce = sh_e(cur_d);
  assign nw = sh_w(next_d);
  assign ne = sh_e(next_d);

  // Life rule per column.
  always_comb begin
    new_row = '0;
    for (int c = 0; c < LINE_W; c++) begin
      new_row[c] = (count8({pw[c], prev_d[c], pe[c], cw[c], ce[c], nw[c], next_d[c], ne[c]}) == 4'd3) |
                   (cur_d[c] &
                    (count8({pw[c], prev_d[c], pe[c], cw[c], ce[c], nw[c], next_d[c], ne[c]}) == 4'd2));
    end
  end

  assign period_hit = run && (per_cnt_q == PER_LAST);
  assign load_go    = (state_q == S_IDLE) && (start || period_hit);

  // Sequencer, window, period counter and registered bus outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      row_q          <= '0;
      ld_cnt_q       <= '0;
      per_cnt_q      <= '0;
      prev_q         <= '0;
      cur_q          <= '0;
      next_q         <= '0;
      cell_write_q   <= 1'b0;
      cell_address_q <= '0;
      cell_data_in_q <= '0;
      world_clock_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      generation_q   <= '0;
    end else begin
      prev_q <= prev_d;
      cur_q  <= cur_d;
      next_q <= next_d;

      // Counts through busy as well so starts are exactly PERIOD cycles apart;
      // a start can only be taken in IDLE since a generation is shorter than PERIOD.
      if (!run || load_go) begin
        per_cnt_q <= '0;
      end else if (per_cnt_q != PER_LAST) begin
        per_cnt_q <= per_cnt_q + CNT_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (load_go) begin
            state_q        <= S_LOAD;
            ld_cnt_q       <= '0;
            busy_q         <= 1'b1;
            cell_address_q <= load_addr(3'd0);
          end
        end
        S_LOAD: begin
          if (ld_cnt_q == 3'd5) begin
            state_q        <= S_WRITE_LO;
            row_q          <= '0;
            cell_write_q   <= 1'b1;
            cell_address_q <= {ROW_W'(0), 1'b0};
            cell_data_in_q <= new_row[DATA_W-1:0];
          end else begin
            ld_cnt_q       <= ld_cnt_q + 3'd1;
            cell_address_q <= load_addr(ld_cnt_q + 3'd1);
          end
        end
        S_WRITE_LO: begin
          state_q        <= S_WRITE_HI;
          cell_address_q <= {row_q, 1'b1};
          cell_data_in_q <= new_row[LINE_W-1:DATA_W];
        end
        S_WRITE_HI: begin
          state_q        <= S_FETCH_LO;
          cell_write_q   <= 1'b0;
          cell_address_q <= {fetch_row, 1'b0};
        end
        S_FETCH_LO: begin
          state_q        <= S_FETCH_HI;
          cell_address_q <= {fetch_row, 1'b1};
        end
        S_FETCH_HI: begin
          if (row_q == LAST_ROW) begin
            state_q        <= S_SWAP;
            cell_address_q <= '0;
            world_clock_q  <= 1'b1;
            done_q         <= 1'b1;
            generation_q   <= generation_q + GEN_WIDTH'(1);
          end else begin
            state_q        <= S_WRITE_LO;
            row_q          <= row_inc;
            cell_write_q   <= 1'b1;
            cell_address_q <= {row_inc, 1'b0};
            cell_data_in_q <= new_row[DATA_W-1:0];
          end
        end
        S_SWAP: begin
          state_q       <= S_IDLE;
          world_clock_q <= 1'b0;
          done_q        <= 1'b0;
          busy_q        <= 1'b0;
        end
        default: begin
          state_q       <= S_IDLE;
          cell_write_q  <= 1'b0;
          world_clock_q <= 1'b0;
          done_q        <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign cell_bus.cell_write   = cell_write_q;
  assign cell_bus.cell_address = cell_address_q;
  assign cell_bus.cell_data_in = cell_data_in_q;
  assign world_clock           = world_clock_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign generation            = generation_q;

endmodule

// File: tb/tb_life_game_step_engine.sv
// Bench for life_game_step_engine: two instances (toroidal and dead-edge) with a
// front-buffer read model; expected back-buffer writes are queued per generation
// and matched against every cell_write the engine issues.
module tb_life_game_step_engine;
  localparam int unsigned ROWS  = 48;
  localparam int unsigned WORDS = 2 * ROWS;
  localparam int unsigned PER   = 300;
  localparam int unsigned LAT   = 6 + 4 * ROWS + 1;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_n       [2];
  logic        start       [2];
  logic        run         [2];
  logic        world_clock [2];
  logic        busy        [2];
  logic        done        [2];
  logic [15:0] generation  [2];
  logic [31:0] world       [2][WORDS];
  logic [31:0] exp_w       [WORDS];

  life_game_step_engine_if bus_a ();
  life_game_step_engine_if bus_b ();

  assign bus_a.cell_data_out = world[0][bus_a.cell_address];
  assign bus_b.cell_data_out = world[1][bus_b.cell_address];

  life_game_step_engine #(.ROWS(ROWS), .WRAP(1'b1), .PERIOD(PER), .GEN_WIDTH(16)) dut_a (
    .clock(clock), .reset_n(rst_n[0]), .start(start[0]), .run(run[0]), .cell_bus(bus_a),
    .world_clock(world_clock[0]), .busy(busy[0]), .done(done[0]), .generation(generation[0]));

  life_game_step_engine #(.ROWS(ROWS), .WRAP(1'b0), .PERIOD(PER), .GEN_WIDTH(16)) dut_b (
    .clock(clock), .reset_n(rst_n[1]), .start(start[1]), .run(run[1]), .cell_bus(bus_b),
    .world_clock(world_clock[1]), .busy(busy[1]), .done(done[1]), .generation(generation[1]));

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  int  nwr    [2];
  int  nwc    [2];
  int  wc_at  [2];
  bit  sb_en  = 1'b1;
  wr_t sbq_a  [$];
  wr_t sbq_b  [$];
  int  wc_hist [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input int d, input logic [6:0] a, input logic [31:0] v);
    wr_t e;
    int  sz;
    nwr[d]++;
    if (!sb_en) return;
    sz = (d == 0) ? sbq_a.size() : sbq_b.size();
    if (sz == 0) begin
      chk("sb_underflow", 64'(sz), 64'(1));
    end else begin
      e = (d == 0) ? sbq_a.pop_front() : sbq_b.pop_front();
      chk("write_addr", 64'(a), 64'(e.addr));
      chk("write_data", 64'(v), 64'(e.data));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (bus_a.cell_write === 1'b1) sb_check(0, bus_a.cell_address, bus_a.cell_data_in);
    if (bus_b.cell_write === 1'b1) sb_check(1, bus_b.cell_address, bus_b.cell_data_in);
    for (int d = 0; d < 2; d++) begin
      if (world_clock[d] !== 1'b0 || done[d] !== 1'b0) begin
        chk("done_eq_wc", 64'(done[d]), 64'(world_clock[d]));
      end
      if (world_clock[d] === 1'b1) begin
        nwc[d]++;
        wc_at[d] = cyc;
        if (d == 0) wc_hist.push_back(cyc);
      end
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < int'(WORDS); i++) begin
      world[0][i] = '0;
      world[1][i] = '0;
      exp_w[i]    = '0;
    end
  endtask

  // One generation on instance d: queue exp_w, pulse start at edge 0, follow timing.
  task automatic run_gen(input int d, input logic [15:0] exp_gen, input bit poke50);
    wr_t e;
    for (int i = 0; i < int'(WORDS); i++) begin
      e.addr = 7'(i);
      e.data = exp_w[i];
      if (d == 0) sbq_a.push_back(e); else sbq_b.push_back(e);
    end
    nwr[d]   = 0;
    nwc[d]   = 0;
    wc_at[d] = 0;
    cyc      = 0;
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    chk("busy_rise", 64'(busy[d]), 64'(1));
    while (cyc < int'(LAT) + 3) begin
      start[d] = (poke50 && cyc == 50);
      tick();
      if (cyc == int'(LAT) + 1) chk("busy_fall", 64'(busy[d]), 64'(0));
    end
    start[d] = 1'b0;
    chk("write_count", 64'(nwr[d]), 64'(WORDS));
    chk("wc_count", 64'(nwc[d]), 64'(1));
    chk("wc_cycle", 64'(wc_at[d]), 64'(LAT));
    chk("sb_drained", 64'((d == 0) ? sbq_a.size() : sbq_b.size()), 64'(0));
    chk("generation", 64'(generation[d]), 64'(exp_gen));
  endtask

  initial begin
    int n0;
    int target;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; start[d] = 1'b0; run[d] = 1'b0;
      nwr[d] = 0; nwc[d] = 0; wc_at[d] = 0;
    end
    clear_all();

    // Reset state
    tick();
    tick();
    chk("rst_busy",     64'(busy[0]),               64'(0));
    chk("rst_wc",       64'(world_clock[0]),        64'(0));
    chk("rst_done",     64'(done[0]),               64'(0));
    chk("rst_gen",      64'(generation[0]),         64'(0));
    chk("rst_write",    64'(bus_a.cell_write),      64'(0));
    chk("rst_addr",     64'(bus_a.cell_address),    64'(0));
    chk("rst_data",     64'(bus_a.cell_data_in),    64'(0));
    chk("rst_busy_b",   64'(busy[1]),               64'(0));
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    tick();
    chk("idle_busy", 64'(busy[0]), 64'(0));

    // Glider, with an ignored start at cycle 50
    world[0][0] = 32'h2; world[0][2] = 32'h4; world[0][4] = 32'h7;
    exp_w[2] = 32'h5; exp_w[4] = 32'h6; exp_w[6] = 32'h2;
    run_gen(0, 16'd1, 1'b1);

    // Blinker, two phases
    clear_all();
    world[0][20] = 32'hE0;
    exp_w[18] = 32'h40; exp_w[20] = 32'h40; exp_w[22] = 32'h40;
    run_gen(0, 16'd2, 1'b0);
    clear_all();
    world[0][18] = 32'h40; world[0][20] = 32'h40; world[0][22] = 32'h40;
    exp_w[20] = 32'hE0;
    run_gen(0, 16'd3, 1'b0);

    // Corner cells: a stable block on the torus, isolated cells without wrap
    clear_all();
    for (int d = 0; d < 2; d++) begin
      world[d][0]  = 32'h0000_0001;
      world[d][1]  = 32'h8000_0000;
      world[d][94] = 32'h0000_0001;
      world[d][95] = 32'h8000_0000;
    end
    exp_w[0] = 32'h0000_0001; exp_w[1] = 32'h8000_0000;
    exp_w[94] = 32'h0000_0001; exp_w[95] = 32'h8000_0000;
    run_gen(0, 16'd4, 1'b0);
    for (int i = 0; i < int'(WORDS); i++) exp_w[i] = '0;
    run_gen(1, 16'd1, 1'b0);

    // Run mode spacing, then drop run mid-generation
    clear_all();
    sb_en = 1'b0;
    cyc = 0;
    wc_hist.delete();
    run[0] = 1'b1;
    repeat (1500) tick();
    chk("run_pulse_count", 64'(wc_hist.size() >= 3), 64'(1));
    for (int i = 1; i < wc_hist.size(); i++) begin
      chk("run_spacing", 64'(wc_hist[i] - wc_hist[i-1]), 64'(PER));
    end
    target = (wc_hist.size() > 0) ? wc_hist[$] + 150 : cyc + 150;
    for (int i = 0; i < 400 && cyc < target; i++) tick();
    chk("run_mid_busy", 64'(busy[0]), 64'(1));
    run[0] = 1'b0;
    n0 = wc_hist.size();
    repeat (800) tick();
    chk("run_drop_pulses", 64'(wc_hist.size() - n0), 64'(1));
    if (wc_hist.size() > n0 && n0 > 0) begin
      chk("run_drop_spacing", 64'(wc_hist[n0] - wc_hist[n0-1]), 64'(PER));
    end
    chk("run_drop_idle", 64'(busy[0]), 64'(0));

    // Reset at cycle 100 of a generation
    clear_all();
    world[0][0] = 32'h2; world[0][2] = 32'h4; world[0][4] = 32'h7;
    cyc = 0;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    while (cyc < 100) tick();
    rst_n[0] = 1'b0;
    #1;
    chk("mid_rst_busy",  64'(busy[0]),            64'(0));
    chk("mid_rst_wc",    64'(world_clock[0]),     64'(0));
    chk("mid_rst_done",  64'(done[0]),            64'(0));
    chk("mid_rst_gen",   64'(generation[0]),      64'(0));
    chk("mid_rst_write", 64'(bus_a.cell_write),   64'(0));
    chk("mid_rst_addr",  64'(bus_a.cell_address), 64'(0));
    chk("mid_rst_data",  64'(bus_a.cell_data_in), 64'(0));
    nwc[0] = 0;
    repeat (5) tick();
    chk("mid_rst_no_wc", 64'(nwc[0]), 64'(0));
    rst_n[0] = 1'b1;
    tick();
    sbq_a.delete();
    sb_en = 1'b1;
    exp_w[2] = 32'h5; exp_w[4] = 32'h6; exp_w[6] = 32'h2;
    run_gen(0, 16'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
